// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed I2C target, byte-wide receive and transmit.
// SCL/SDA are oversampled by clk; SDA is driven open-drain via sda_oe.
// SCL is only observed, never stretched.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1100101
) (
    input  logic       clk,
    input  logic       rs,
    input  logic       scl,
    input  logic       sda,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rw_flag,
    output logic       busy,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_RX       = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_TX       = 3'd5,
        ST_TX_ACK   = 3'd6
    } state_e;

    // Synchroniser stages plus one history flop per pin.
    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    // Protocol state.
    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic       byte_done_q;
    logic       mst_ack_q;

    // Registered outputs.
    logic       sda_oe_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       tx_req_q;
    logic       rw_q;
    logic       busy_q;
    logic       stop_det_q;

    // Decoded bus events on the synchronised levels.
    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       start_s;
    logic       stop_s;
    logic [7:0] rx_byte_d;

    assign scl_rise_s = scl_s2_q & ~scl_h_q;
    assign scl_fall_s = ~scl_s2_q & scl_h_q;
    // Conditions are qualified with the current synchronised SCL so that an
    // SDA change arriving together with an SCL fall is not taken as START/STOP.
    assign start_s    = scl_s2_q & sda_h_q & ~sda_s2_q;
    assign stop_s     = scl_s2_q & ~sda_h_q & sda_s2_q;
    // Byte as it stands once the bit currently on SDA is shifted in.
    assign rx_byte_d  = {shift_q, sda_s2_q};

    // Bring SCL/SDA into the clk domain; reset to the idle-bus level (high)
    // so that leaving reset never looks like a START or STOP.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= sda;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    // Protocol FSM: samples SDA on SCL rises, changes SDA drive only on SCL
    // falls; START/STOP take precedence over any SCL edge in the same clk.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            byte_done_q <= 1'b0;
            mst_ack_q   <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            stop_det_q <= 1'b0;
            if (start_s) begin
                // A (repeated) START always restarts address reception.
                state_q     <= ST_ADDR;
                bit_cnt_q   <= 3'd0;
                byte_done_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
            end else if (stop_s) begin
                state_q     <= ST_IDLE;
                bit_cnt_q   <= 3'd0;
                byte_done_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
                stop_det_q  <= busy_q;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        sda_oe_q <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_q   <= rx_byte_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (rx_byte_d[7:1] == SLAVE_ADDR) begin
                                    rw_q        <= rx_byte_d[0];
                                    busy_q      <= 1'b1;
                                    byte_done_q <= 1'b1;
                                end else begin
                                    // Not for us: stay off the bus until next START.
                                    state_q  <= ST_IDLE;
                                    sda_oe_q <= 1'b0;
                                end
                            end
                        end else if (scl_fall_s && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            sda_oe_q    <= 1'b1;
                            state_q     <= ST_ADDR_ACK;
                        end
                    end
                    ST_ADDR_ACK: begin
                        // ACK is held through the 9th high phase; act on its fall.
                        if (scl_fall_s) begin
                            bit_cnt_q <= 3'd0;
                            if (rw_q) begin
                                shift_q  <= tx_data[6:0];
                                sda_oe_q <= ~tx_data[7];
                                tx_req_q <= 1'b1;
                                state_q  <= ST_TX;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= ST_RX;
                            end
                        end
                    end
                    ST_RX: begin
                        if (scl_rise_s) begin
                            shift_q   <= rx_byte_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_q   <= rx_byte_d;
                                rx_valid_q  <= 1'b1;
                                byte_done_q <= 1'b1;
                            end
                        end else if (scl_fall_s && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            sda_oe_q    <= 1'b1;
                            state_q     <= ST_RX_ACK;
                        end
                    end
                    ST_RX_ACK: begin
                        if (scl_fall_s) begin
                            sda_oe_q  <= 1'b0;
                            bit_cnt_q <= 3'd0;
                            state_q   <= ST_RX;
                        end
                    end
                    ST_TX: begin
                        if (scl_rise_s) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_done_q <= 1'b1;
                            end
                        end else if (scl_fall_s) begin
                            if (byte_done_q) begin
                                // Hand SDA to the master for its ACK/NACK.
                                byte_done_q <= 1'b0;
                                sda_oe_q    <= 1'b0;
                                state_q     <= ST_TX_ACK;
                            end else begin
                                sda_oe_q <= ~shift_q[6];
                                shift_q  <= {shift_q[5:0], 1'b0};
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise_s) begin
                            if (sda_s2_q) begin
                                // NACK ends the read; SDA is already released.
                                mst_ack_q <= 1'b0;
                                sda_oe_q  <= 1'b0;
                                busy_q    <= 1'b0;
                                state_q   <= ST_IDLE;
                            end else begin
                                mst_ack_q <= 1'b1;
                            end
                        end else if (scl_fall_s && mst_ack_q) begin
                            mst_ack_q <= 1'b0;
                            bit_cnt_q <= 3'd0;
                            shift_q   <= tx_data[6:0];
                            sda_oe_q  <= ~tx_data[7];
                            tx_req_q  <= 1'b1;
                            state_q   <= ST_TX;
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        bit_cnt_q   <= 3'd0;
                        byte_done_q <= 1'b0;
                        sda_oe_q    <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign rw_flag  = rw_q;
    assign busy     = busy_q;
    assign stop_det = stop_det_q;

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b1100101, the 7-bit address the block acknowledges.
REQ-002 SHALL have port clk, input, 1, the system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rs, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port scl, input, 1, the I2C clock pin level (asynchronous to clk).
REQ-005 SHALL have port sda, input, 1, the I2C data pin level (asynchronous to clk).
REQ-006 SHALL have port sda_oe, output, 1: 1 pulls SDA low, 0 releases it (open-drain).
REQ-007 SHALL have port rx_data, output, 8, the last byte received from the master.
REQ-008 SHALL have port rx_valid, output, 1, a one-clk pulse when rx_data updates.
REQ-009 SHALL have port tx_data, input, 8, the byte to send to the master on reads.
REQ-010 SHALL have port tx_req, output, 1, a one-clk pulse when tx_data is sampled into the shifter.
REQ-011 SHALL have port rw_flag, output, 1, the latched R/W bit of the last matched address.
REQ-012 SHALL have port busy, output, 1, high while the block is addressed (ADDR_ACK through the end of the transfer).
REQ-013 SHALL have port stop_det, output, 1, a one-clk pulse on STOP while busy.

Function
REQ-014 SHALL pass scl and sda through 2-flop synchronisers plus one history flop each; edges are detected on the synchronised values.
REQ-015 SHALL detect START as a synchronised sda fall while synchronised scl is high, and STOP as a synchronised sda rise while synchronised scl is high.
REQ-016 SHALL give START/STOP priority over scl edges in the same clk.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, with a 3-bit bit counter; data is MSB first.
REQ-018 SHALL, on START in any state (including a repeated start), enter ADDR, clear the bit counter and release sda_oe in the same clk.
REQ-019 SHALL, on STOP in any state, enter IDLE and release sda_oe; stop_det pulses only if busy was 1.
REQ-020 SHALL sample sda on each synchronised scl rise and change sda_oe only on synchronised scl falls.
REQ-021 ADDR SHALL shift 8 bits; after the 8th rise, on an address match, latch rw_flag and set busy; on the next fall, drive sda_oe=1 (ACK) and enter ADDR_ACK.
REQ-022 SHALL, on an address mismatch, go to IDLE with sda_oe=0 and ignore the bus until the next START.
REQ-023 ADDR_ACK SHALL hold the ACK through the 9th scl high. On the 9th fall: if rw=0, release SDA and enter RX; if rw=1, load tx_data, pulse tx_req, drive sda_oe=~tx_data[7] and enter TX.
REQ-024 RX SHALL, on the 8th rise, update rx_data and pulse rx_valid in the following clk; on the next fall it SHALL drive the ACK and enter RX_ACK.
REQ-025 RX_ACK SHALL, on the 9th fall, release SDA and return to RX with the bit counter cleared.
REQ-026 TX SHALL drive sda_oe=~bit on each fall for bits 6..0; after the 8th bit's fall it SHALL release SDA and enter TX_ACK.
REQ-027 TX_ACK SHALL sample the master's bit on the 9th rise:
- 0 (ACK): on the next fall, load tx_data, pulse tx_req and drive the MSB in TX.
- 1 (NACK): release SDA, clear busy and enter IDLE.
REQ-028 SHALL update sda_oe within 4 clk of the scl pin falling edge; the bus SHALL keep SCL low and high phases at 8 clk or more.
REQ-029 SHALL NOT stretch SCL; it never drives scl.

Reset
REQ-030 SHALL, while rs=0, force state IDLE, bit counter 0 and every output 0 (rx_data=8'h00).
REQ-031 SHALL reset the synchroniser and history flops to 1 (bus idle) so that no false START/STOP appears at reset release.
REQ-032 SHALL, on reset mid-transfer, release SDA immediately and ignore the bus until the next START.

Verification
REQ-033 Write: START, 0xCA (addr 0x65, W), bytes 0x5A and 0xA5, STOP -> three ACKs; rx_valid twice with rx_data 0x5A then 0xA5; rw_flag=0; stop_det once.
REQ-034 Read: START, 0xCB, tx_data=0x3C then 0xC3, master ACKs the first byte and NACKs the second, STOP -> SDA carries 0x3C,0xC3; tx_req twice; busy drops after the NACK.
REQ-035 Mismatch: START, 0xBA (addr 0x5D), byte 0xFF, STOP -> sda_oe stays 0; no rx_valid or stop_det.
REQ-036 Repeated start: write 0xCA, byte 0x01, then START 0xCB, read one byte with NACK -> ACKs on the write phase; rw_flag becomes 1; tx_req once.
REQ-037 Reset mid-byte: rs low for 10 ns during the 4th bit of a write data byte -> sda_oe=0 and outputs 0 at once; the next full write transaction completes correctly.
